// File: rtl/ucontroller_pkg.sv
// Shared definitions for the microcontroller bus fabric: arbiter state
// encoding and default arbitration timing parameters.
package ucontroller_pkg;

    localparam int unsigned MAX_TENURE_DEFAULT     = 64;
    localparam int unsigned MIN_CPU_CYCLES_DEFAULT = 4;

    typedef enum logic [1:0] {
        CPU_OWN  = 2'd0,
        HOLD_REQ = 2'd1,
        DMA_OWN  = 2'd2,
        RELEASE  = 2'd3
    } bus_arb_state_t;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/bus_arbiter.sv
// CPU/DMA RAM bus arbiter: hands the RAM port to the DMA engine after the CPU
// acknowledges a hold, bounds DMA tenure, and enforces a minimum CPU window
// between DMA tenures. One counter serves both as the CPU gap counter (in
// CPU_OWN) and the DMA tenure counter (in DMA_OWN).
module bus_arbiter
    import ucontroller_pkg::*;
#(
    parameter int unsigned MAX_TENURE     = MAX_TENURE_DEFAULT,
    parameter int unsigned MIN_CPU_CYCLES = MIN_CPU_CYCLES_DEFAULT
) (
    input  logic       Clk,
    input  logic       Rst_n,
    input  logic       Bus_req,
    output logic       Bus_grant,
    output logic       Cpu_hold,
    input  logic       Cpu_ack,
    output logic       Dma_timeout,
    input  logic [7:0] Cpu_address,
    input  logic [7:0] Dma_address,
    input  logic       Cpu_cs,
    input  logic       Dma_cs,
    input  logic       Cpu_we,
    input  logic       Dma_we,
    input  logic [7:0] Cpu_data_out,
    input  logic [7:0] Dma_data_out,
    output logic [7:0] Ram_address,
    output logic       Ram_cs,
    output logic       Ram_we,
    output logic [7:0] Ram_data_in
);

    localparam int unsigned CW = $clog2(max_u(MAX_TENURE, MIN_CPU_CYCLES) + 1);
    localparam logic [CW-1:0] MIN_C    = CW'(MIN_CPU_CYCLES);
    localparam logic [CW-1:0] TEN_LAST = CW'(MAX_TENURE - 1);

    bus_arb_state_t  state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            timeout_q, timeout_d;

    // Next-state, shared counter and timeout pulse computation.
    // The counter is cleared on every state change, so it reads as
    // cpu_cycles in CPU_OWN and tenure_cnt in DMA_OWN.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        timeout_d = 1'b0;
        case (state_q)
            CPU_OWN: begin
                if (Bus_req && (cnt_q >= MIN_C)) begin
                    state_d = HOLD_REQ;
                    cnt_d   = '0;
                end else if (cnt_q < MIN_C) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            HOLD_REQ: begin
                cnt_d = '0;
                if (!Bus_req) begin
                    state_d = CPU_OWN;
                end else if (Cpu_ack) begin
                    state_d = DMA_OWN;
                end
            end
            DMA_OWN: begin
                if (!Bus_req) begin
                    state_d = RELEASE;
                    cnt_d   = '0;
                end else if (cnt_q == TEN_LAST) begin
                    state_d   = RELEASE;
                    cnt_d     = '0;
                    timeout_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RELEASE: begin
                state_d = CPU_OWN;
                cnt_d   = '0;
            end
            default: begin
                state_d = CPU_OWN;
                cnt_d   = '0;
            end
        endcase
    end

    // State, counter and timeout registers; reset pre-satisfies the CPU gap.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q   <= CPU_OWN;
            cnt_q     <= MIN_C;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign Bus_grant   = (state_q == DMA_OWN);
    assign Cpu_hold    = (state_q == HOLD_REQ) || (state_q == DMA_OWN);
    assign Dma_timeout = timeout_q;

    // RAM port mux: CPU until the DMA owns the bus, idle during RELEASE.
    always_comb begin
        Ram_address = '0;
        Ram_cs      = 1'b0;
        Ram_we      = 1'b0;
        Ram_data_in = '0;
        case (state_q)
            CPU_OWN, HOLD_REQ: begin
                Ram_address = Cpu_address;
                Ram_cs      = Cpu_cs;
                Ram_we      = Cpu_we;
                Ram_data_in = Cpu_data_out;
            end
            DMA_OWN: begin
                Ram_address = Dma_address;
                Ram_cs      = Dma_cs;
                Ram_we      = Dma_we;
                Ram_data_in = Dma_data_out;
            end
            default: ;
        endcase
    end

endmodule
